// File: rtl/xgmac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xgmac_pkg
//  Purpose  : Shared constants for the XGMAC IPIF register block: register
//             byte offsets, interrupt bit indices and FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package xgmac_pkg;

    // Register byte offsets (11-bit IPIF address space)
    localparam logic [10:0] c_addr_id         = 11'h000;
    localparam logic [10:0] c_addr_ctrl       = 11'h004;
    localparam logic [10:0] c_addr_status     = 11'h008;
    localparam logic [10:0] c_addr_int_status = 11'h00C;
    localparam logic [10:0] c_addr_int_enable = 11'h010;
    localparam logic [10:0] c_addr_scratch    = 11'h014;
    localparam logic [10:0] c_addr_dbg_txd_lo = 11'h020;
    localparam logic [10:0] c_addr_dbg_txd_hi = 11'h024;
    localparam logic [10:0] c_addr_dbg_rxd_lo = 11'h028;
    localparam logic [10:0] c_addr_dbg_rxd_hi = 11'h02C;
    localparam logic [10:0] c_addr_dbg_snap   = 11'h030;
    localparam logic [10:0] c_addr_dbg_ctl    = 11'h034;

    // Interrupt bit positions in INT_STATUS / INT_ENABLE
    localparam int c_int_xgmac   = 0;
    localparam int c_int_rstdone = 1;

    // Bus access FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_decode = 2'd1;
    localparam state_t c_st_ack    = 2'd2;
    localparam state_t c_st_wait   = 2'd3;

endpackage : xgmac_pkg
`default_nettype wire

// File: rtl/xgmac_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : xgmac_edge_det
//  Purpose  : Per-bit rise/fall pulse generator. Compares each input against
//             its value from the previous cycle; pulses are combinational
//             from the registered history.
//  Revision : 1.0 - initial release
// ============================================================================
module xgmac_edge_det #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_prev;

    // History register; reset loads the live inputs so no edge fires on release
    always_ff @(posedge clk) begin
        r_prev <= i_din;
        if (!rst_n) begin
            r_prev <= i_din;
        end
    end

    assign o_rise = i_din & ~r_prev;
    assign o_fall = ~i_din & r_prev;

endmodule : xgmac_edge_det
`default_nettype wire

// File: rtl/xgmac_ipif_regs.sv
`default_nettype none
// ============================================================================
//  Module   : xgmac_ipif_regs
//  Purpose  : IPIF slave register block for the XGMAC core: ID, CTRL, STATUS,
//             W1C interrupt status, interrupt enable, scratch, level irq.
//             Optional XGMII debug snapshot registers when the macro
//             XGMAC_DBG_CAPTURE_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module xgmac_ipif_regs
    import xgmac_pkg::*;
#(
    parameter logic [31:0] C_VERSION  = 32'h0100_0000,
    parameter logic [31:0] C_CTRL_RST = 32'h0000_0003
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_resetn,
    input  logic        bus2ip_cs,
    input  logic        bus2ip_rnw,
    input  logic [10:0] bus2ip_addr,
    input  logic [31:0] bus2ip_data,
    output logic [31:0] ip2bus_data,
    output logic        ip2bus_rdack,
    output logic        ip2bus_wrack,
    output logic        ip2bus_error,
    input  logic [7:0]  core_status,
    input  logic        resetdone,
    input  logic        xgmacint,
    input  logic [63:0] xgmii_txd_dbg,
    input  logic [63:0] xgmii_rxd_dbg,
    input  logic [7:0]  xgmii_txc_dbg,
    input  logic [7:0]  xgmii_rxc_dbg,
    output logic [31:0] ctrl,
    output logic        irq
);

    state_t      r_state;
    logic        r_cs_d;      // cs last cycle; reset to 1 so a held cs must drop first
    logic [10:0] r_addr;
    logic        r_rnw;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_rdack;
    logic        r_wrack;
    logic        r_error;
    logic [31:0] r_ctrl;
    logic [1:0]  r_int_status;
    logic [1:0]  r_int_enable;
    logic [31:0] r_scratch;
    logic        r_irq;

    logic        w_mapped;
    logic        w_err;
    logic [31:0] w_rd_mux;
    logic        w_wr_en;
    logic [1:0]  w_edge_in;
    logic [1:0]  w_rise;
    logic [1:0]  w_fall;
    logic [1:0]  w_int_set;
    logic [1:0]  w_int_clr;

`ifdef XGMAC_DBG_CAPTURE_EN
    logic [63:0] r_dbg_txd;
    logic [63:0] r_dbg_rxd;
    logic [7:0]  r_dbg_txc;
    logic [7:0]  r_dbg_rxc;
`else
    logic        w_unused_dbg;
    assign w_unused_dbg = ^{xgmii_txd_dbg, xgmii_rxd_dbg, xgmii_txc_dbg, xgmii_rxc_dbg};
`endif

    // Register decode and read mux on the captured address
    always_comb begin
        w_mapped = 1'b1;
        w_rd_mux = 32'd0;
        case (r_addr)
            c_addr_id:         w_rd_mux = C_VERSION;
            c_addr_ctrl:       w_rd_mux = r_ctrl;
            c_addr_status:     w_rd_mux = {23'd0, resetdone, core_status};
            c_addr_int_status: w_rd_mux = {30'd0, r_int_status};
            c_addr_int_enable: w_rd_mux = {30'd0, r_int_enable};
            c_addr_scratch:    w_rd_mux = r_scratch;
`ifdef XGMAC_DBG_CAPTURE_EN
            c_addr_dbg_txd_lo: w_rd_mux = r_dbg_txd[31:0];
            c_addr_dbg_txd_hi: w_rd_mux = r_dbg_txd[63:32];
            c_addr_dbg_rxd_lo: w_rd_mux = r_dbg_rxd[31:0];
            c_addr_dbg_rxd_hi: w_rd_mux = r_dbg_rxd[63:32];
            c_addr_dbg_snap:   w_rd_mux = 32'd0;
            c_addr_dbg_ctl:    w_rd_mux = {16'd0, r_dbg_rxc, r_dbg_txc};
`endif
            default:           w_mapped = 1'b0;
        endcase
    end

    assign w_err   = !w_mapped || (r_addr[1:0] != 2'b00);
    assign w_wr_en = (r_state == c_st_decode) && !r_rnw && !w_err;

    // Bus access FSM with request capture and registered acknowledge
    always_ff @(posedge bus2ip_clk) begin
        r_cs_d  <= bus2ip_cs;
        r_rdack <= 1'b0;
        r_wrack <= 1'b0;
        r_error <= 1'b0;
        r_rdata <= 32'd0;
        case (r_state)
            c_st_idle: begin
                if (bus2ip_cs) begin
                    if (r_cs_d) begin
                        r_state <= c_st_wait;
                    end else begin
                        r_state <= c_st_decode;
                        r_addr  <= bus2ip_addr;
                        r_rnw   <= bus2ip_rnw;
                        r_wdata <= bus2ip_data;
                    end
                end
            end
            c_st_decode: begin
                r_state <= c_st_ack;
                r_rdack <= r_rnw;
                r_wrack <= !r_rnw;
                r_error <= w_err;
                r_rdata <= (r_rnw && !w_err) ? w_rd_mux : 32'd0;
            end
            c_st_ack: begin
                r_state <= c_st_wait;
            end
            default: begin
                if (!bus2ip_cs) begin
                    r_state <= c_st_idle;
                end
            end
        endcase
        if (!bus2ip_resetn) begin
            r_state <= c_st_idle;
            r_cs_d  <= 1'b1;
            r_addr  <= 11'd0;
            r_rnw   <= 1'b1;
            r_wdata <= 32'd0;
            r_rdack <= 1'b0;
            r_wrack <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= 32'd0;
        end
    end

    // Interrupt edge detection: bit0 on xgmacint rise, bit1 on resetdone fall
    assign w_edge_in[c_int_xgmac]   = xgmacint;
    assign w_edge_in[c_int_rstdone] = resetdone;

    xgmac_edge_det #(
        .WIDTH (2)
    ) u_edge_det (
        .clk    (bus2ip_clk),
        .rst_n  (bus2ip_resetn),
        .i_din  (w_edge_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_int_set[c_int_xgmac]   = w_rise[c_int_xgmac];
    assign w_int_set[c_int_rstdone] = w_fall[c_int_rstdone];
    assign w_int_clr = (w_wr_en && r_addr == c_addr_int_status) ? r_wdata[1:0] : 2'b00;

    // Writable registers; a set event beats a same-cycle W1C clear
    always_ff @(posedge bus2ip_clk) begin
        r_int_status <= (r_int_status & ~w_int_clr) | w_int_set;
        r_irq        <= |(r_int_status & r_int_enable);
        if (w_wr_en) begin
            case (r_addr)
                c_addr_ctrl:       r_ctrl       <= r_wdata;
                c_addr_int_enable: r_int_enable <= r_wdata[1:0];
                c_addr_scratch:    r_scratch    <= r_wdata;
                default:           ;
            endcase
        end
        if (!bus2ip_resetn) begin
            r_ctrl       <= C_CTRL_RST;
            r_int_status <= 2'b00;
            r_int_enable <= 2'b00;
            r_scratch    <= 32'd0;
            r_irq        <= 1'b0;
        end
    end

`ifdef XGMAC_DBG_CAPTURE_EN
    // XGMII debug snapshot, taken on any write to the snapshot offset
    always_ff @(posedge bus2ip_clk) begin
        if (w_wr_en && r_addr == c_addr_dbg_snap) begin
            r_dbg_txd <= xgmii_txd_dbg;
            r_dbg_rxd <= xgmii_rxd_dbg;
            r_dbg_txc <= xgmii_txc_dbg;
            r_dbg_rxc <= xgmii_rxc_dbg;
        end
        if (!bus2ip_resetn) begin
            r_dbg_txd <= 64'd0;
            r_dbg_rxd <= 64'd0;
            r_dbg_txc <= 8'd0;
            r_dbg_rxc <= 8'd0;
        end
    end
`endif

    assign ip2bus_data  = r_rdata;
    assign ip2bus_rdack = r_rdack;
    assign ip2bus_wrack = r_wrack;
    assign ip2bus_error = r_error;
    assign ctrl         = r_ctrl;
    assign irq          = r_irq;

endmodule : xgmac_ipif_regs
`default_nettype wire

// File: tb/tb_xgmac_ipif_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xgmac_ipif_regs
//  Purpose  : Directed self-checking bench for xgmac_ipif_regs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xgmac_ipif_regs;

    logic        clk = 1'b0;
    logic        bus2ip_resetn;
    logic        bus2ip_cs;
    logic        bus2ip_rnw;
    logic [10:0] bus2ip_addr;
    logic [31:0] bus2ip_data;
    logic [31:0] ip2bus_data;
    logic        ip2bus_rdack;
    logic        ip2bus_wrack;
    logic        ip2bus_error;
    logic [7:0]  core_status;
    logic        resetdone;
    logic        xgmacint;
    logic [63:0] xgmii_txd_dbg;
    logic [63:0] xgmii_rxd_dbg;
    logic [7:0]  xgmii_txc_dbg;
    logic [7:0]  xgmii_rxc_dbg;
    logic [31:0] ctrl;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xgmac_ipif_regs dut (
        .bus2ip_clk    (clk),
        .bus2ip_resetn (bus2ip_resetn),
        .bus2ip_cs     (bus2ip_cs),
        .bus2ip_rnw    (bus2ip_rnw),
        .bus2ip_addr   (bus2ip_addr),
        .bus2ip_data   (bus2ip_data),
        .ip2bus_data   (ip2bus_data),
        .ip2bus_rdack  (ip2bus_rdack),
        .ip2bus_wrack  (ip2bus_wrack),
        .ip2bus_error  (ip2bus_error),
        .core_status   (core_status),
        .resetdone     (resetdone),
        .xgmacint      (xgmacint),
        .xgmii_txd_dbg (xgmii_txd_dbg),
        .xgmii_rxd_dbg (xgmii_rxd_dbg),
        .xgmii_txc_dbg (xgmii_txc_dbg),
        .xgmii_rxc_dbg (xgmii_rxc_dbg),
        .ctrl          (ctrl),
        .irq           (irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus access; cs held for 'hold' cycles, bus inputs scrambled after capture
    task automatic bus_xfer(input logic [10:0] addr, input logic rnw, input logic [31:0] wdata,
                            input int hold, output logic [31:0] rdata, output int n_rd,
                            output int n_wr, output int n_err, output int ack_cyc);
        rdata = 32'd0; n_rd = 0; n_wr = 0; n_err = 0; ack_cyc = -1;
        bus2ip_cs   = 1'b1;
        bus2ip_addr = addr;
        bus2ip_rnw  = rnw;
        bus2ip_data = wdata;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            bus2ip_addr = 11'h7FC;
            bus2ip_data = ~wdata;
            bus2ip_rnw  = ~rnw;
            if (ip2bus_rdack) n_rd++;
            if (ip2bus_wrack) n_wr++;
            if (ip2bus_error) n_err++;
            if ((ip2bus_rdack || ip2bus_wrack) && ack_cyc < 0) begin
                ack_cyc = k;
                rdata   = ip2bus_data;
            end
        end
        bus2ip_cs = 1'b0;
        @(posedge clk); #1;
        if (ip2bus_rdack) n_rd++;
        if (ip2bus_wrack) n_wr++;
    endtask

    task automatic rd_chk(input string tag, input logic [10:0] addr, input logic [31:0] exp,
                          input logic exp_err);
        logic [31:0] d;
        int nr, nw, ne, ac;
        bus_xfer(addr, 1'b1, 32'd0, 4, d, nr, nw, ne, ac);
        check({tag, "_data"}, d, exp);
        check({tag, "_rdack"}, nr, 1);
        check({tag, "_wrack"}, nw, 0);
        check({tag, "_err"}, ne, exp_err);
    endtask

    task automatic wr_chk(input string tag, input logic [10:0] addr, input logic [31:0] wdata,
                          input logic exp_err);
        logic [31:0] d;
        int nr, nw, ne, ac;
        bus_xfer(addr, 1'b0, wdata, 4, d, nr, nw, ne, ac);
        check({tag, "_wrack"}, nw, 1);
        check({tag, "_rdack"}, nr, 0);
        check({tag, "_err"}, ne, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int nr, nw, ne, ac;

        bus2ip_resetn = 1'b0;
        bus2ip_cs     = 1'b0;
        bus2ip_rnw    = 1'b1;
        bus2ip_addr   = 11'd0;
        bus2ip_data   = 32'd0;
        core_status   = 8'hA5;
        resetdone     = 1'b1;
        xgmacint      = 1'b0;
        xgmii_txd_dbg = 64'd0;
        xgmii_rxd_dbg = 64'd0;
        xgmii_txc_dbg = 8'd0;
        xgmii_rxc_dbg = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdack", ip2bus_rdack, 0);
        check("rst_wrack", ip2bus_wrack, 0);
        check("rst_error", ip2bus_error, 0);
        check("rst_data", ip2bus_data, 0);
        check("rst_ctrl", ctrl, 32'h3);
        check("rst_irq", irq, 0);
        bus2ip_resetn = 1'b1;
        @(posedge clk); #1;

        // ID read with ack latency
        bus_xfer(11'h000, 1'b1, 32'd0, 4, d, nr, nw, ne, ac);
        check("id_ackcyc", ac, 2);
        check("id_data", d, 32'h0100_0000);
        check("id_rdack", nr, 1);
        check("id_err", ne, 0);

        // Scratch round trip, CTRL untouched
        wr_chk("scr_wr", 11'h014, 32'hDEAD_BEEF, 1'b0);
        rd_chk("scr_rd", 11'h014, 32'hDEAD_BEEF, 1'b0);
        check("ctrl_keep", ctrl, 32'h3);

        // Unmapped read with cs held high for 10 cycles
        bus_xfer(11'h3FC, 1'b1, 32'd0, 10, d, nr, nw, ne, ac);
        check("unm_data", d, 0);
        check("unm_rdack", nr, 1);
        check("unm_err", ne, 1);
        check("unm_wrack", nw, 0);

        rd_chk("misal", 11'h005, 32'd0, 1'b1);
        rd_chk("unm018", 11'h018, 32'd0, 1'b1);
        rd_chk("status", 11'h008, 32'h0000_01A5, 1'b0);

        // RO write ignored
        wr_chk("id_wr", 11'h000, 32'h1234_5678, 1'b0);
        rd_chk("id_rd2", 11'h000, 32'h0100_0000, 1'b0);

        wr_chk("ctrl_wr", 11'h004, 32'h1234_5678, 1'b0);
        check("ctrl_out", ctrl, 32'h1234_5678);
        rd_chk("ctrl_rd", 11'h004, 32'h1234_5678, 1'b0);

        // Interrupt enable masks to two bits
        wr_chk("ien_wr", 11'h010, 32'hFFFF_FFFF, 1'b0);
        rd_chk("ien_rd", 11'h010, 32'h3, 1'b0);

        // xgmacint rising edge sets bit0 and raises irq
        xgmacint = 1'b1;
        @(posedge clk); #1;
        xgmacint = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("irq_set", irq, 1);
        rd_chk("ist_1", 11'h00C, 32'h1, 1'b0);
        wr_chk("ist_w1c", 11'h00C, 32'h1, 1'b0);
        check("irq_clr", irq, 0);
        rd_chk("ist_0", 11'h00C, 32'h0, 1'b0);

        // W1C coincident with a new xgmacint edge: set wins
        xgmacint = 1'b1;
        @(posedge clk); #1;
        xgmacint = 1'b0;
        @(posedge clk); #1;
        bus2ip_cs   = 1'b1;
        bus2ip_addr = 11'h00C;
        bus2ip_rnw  = 1'b0;
        bus2ip_data = 32'h1;
        @(posedge clk); #1;
        xgmacint = 1'b1;
        @(posedge clk); #1;
        check("coin_wrack", ip2bus_wrack, 1);
        @(posedge clk); #1;
        bus2ip_cs = 1'b0;
        @(posedge clk); #1;
        rd_chk("coin_ist", 11'h00C, 32'h1, 1'b0);
        check("coin_irq", irq, 1);
        xgmacint = 1'b0;

        // resetdone falling edge sets bit1
        resetdone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rd_chk("ist_3", 11'h00C, 32'h3, 1'b0);
        resetdone = 1'b1;
        wr_chk("ien_off", 11'h010, 32'h0, 1'b0);
        check("irq_masked", irq, 0);

        // Reset asserted during DECODE of a CTRL write, cs held through release
        bus2ip_cs   = 1'b1;
        bus2ip_addr = 11'h004;
        bus2ip_rnw  = 1'b0;
        bus2ip_data = 32'h0;
        @(posedge clk); #1;
        bus2ip_resetn = 1'b0;
        @(posedge clk); #1;
        check("abort_wrack", ip2bus_wrack, 0);
        check("abort_ctrl", ctrl, 32'h3);
        bus2ip_resetn = 1'b1;
        nw = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ip2bus_wrack || ip2bus_rdack) nw++;
        end
        check("abort_noack", nw, 0);
        bus2ip_cs = 1'b0;
        @(posedge clk); #1;
        rd_chk("abort_ctrl_rd", 11'h004, 32'h3, 1'b0);
        rd_chk("abort_ist", 11'h00C, 32'h0, 1'b0);
        check("abort_irq", irq, 0);

`ifdef XGMAC_DBG_CAPTURE_EN
        xgmii_txd_dbg = 64'h0123_4567_89AB_CDEF;
        xgmii_rxd_dbg = 64'hFEDC_BA98_7654_3210;
        xgmii_txc_dbg = 8'h5A;
        xgmii_rxc_dbg = 8'hC3;
        wr_chk("dbg_snap", 11'h030, 32'h0, 1'b0);
        xgmii_txd_dbg = 64'd0;
        xgmii_rxd_dbg = 64'd0;
        xgmii_txc_dbg = 8'd0;
        xgmii_rxc_dbg = 8'd0;
        rd_chk("dbg_txlo", 11'h020, 32'h89AB_CDEF, 1'b0);
        rd_chk("dbg_txhi", 11'h024, 32'h0123_4567, 1'b0);
        rd_chk("dbg_rxlo", 11'h028, 32'h7654_3210, 1'b0);
        rd_chk("dbg_ctl", 11'h034, 32'h0000_C35A, 1'b0);
`else
        rd_chk("dbg_off", 11'h020, 32'd0, 1'b1);
        wr_chk("dbg_snap_off", 11'h030, 32'h0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_xgmac_ipif_regs
`default_nettype wire
